// File: rtl/hs_slave_fifo_if.sv
// Valid/ready channel pair for hs_slave_fifo: one input channel and one output channel.
interface hs_slave_fifo_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data_out;
    logic              out_valid;
    logic              out_ready;

    modport slave (
        input  data,
        input  valid,
        output ready,
        output data_out,
        output out_valid,
        input  out_ready
    );

    modport master (
        output data,
        output valid,
        input  ready,
        input  data_out,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/hs_slave_fifo.sv
// Valid/ready slave with a DEPTH-entry first-word fall-through FIFO.
// Optional HS_FIFO_STATS_EN adds the xfer_cnt and stall_seen statistics outputs.
module hs_slave_fifo #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 4,
    parameter int AFULL_TH = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    hs_slave_fifo_if.slave         bus,
    output logic [$clog2(DEPTH):0] count,
    output logic                   afull
`ifdef HS_FIFO_STATS_EN
    ,
    output logic [31:0]            xfer_cnt,
    output logic                   stall_seen
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AFULL = CW'(AFULL_TH);
    localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic [CW-1:0]     count_next_s;
    logic              ready_r;
    logic              out_valid_r;
    logic              afull_r;
    logic              push_s;
    logic              pop_s;

    // Handshake decode and next occupancy; ready is a register so a full FIFO
    // never accepts a beat even when a pop happens in the same cycle.
    always_comb begin
        push_s       = bus.valid && ready_r;
        pop_s        = out_valid_r && bus.out_ready;
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // Pointers, occupancy and the status flags all registered from the next count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            count_r     <= CNT_ZERO;
            ready_r     <= 1'b0;
            out_valid_r <= 1'b0;
            afull_r     <= 1'b0;
        end else begin
            count_r     <= count_next_s;
            ready_r     <= (count_next_s != CNT_FULL);
            out_valid_r <= (count_next_s != CNT_ZERO);
            afull_r     <= (count_next_s >= CNT_AFULL);
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Storage array; contents survive reset and are masked by out_valid instead.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= bus.data;
        end
    end

    assign bus.ready     = ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.data_out  = out_valid_r ? mem_r[rd_ptr_r] : {DATA_W{1'b0}};
    assign count         = count_r;
    assign afull         = afull_r;

`ifdef HS_FIFO_STATS_EN
    logic [31:0] xfer_cnt_r;
    logic        stall_seen_r;

    // Accepted-beat counter (natural 32-bit wrap) and sticky input-stall flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt_r   <= 32'd0;
            stall_seen_r <= 1'b0;
        end else begin
            if (push_s) begin
                xfer_cnt_r <= xfer_cnt_r + 32'd1;
            end
            if (bus.valid && !ready_r) begin
                stall_seen_r <= 1'b1;
            end
        end
    end

    assign xfer_cnt   = xfer_cnt_r;
    assign stall_seen = stall_seen_r;
`endif

endmodule

// File: tb/tb_hs_slave_fifo.sv
// Scoreboard bench for hs_slave_fifo with default parameters (DATA_W=32, DEPTH=4, AFULL_TH=3).
module tb_hs_slave_fifo;

    logic        clk;
    logic        rst_n;
    logic [2:0]  count;
    logic        afull;
`ifdef HS_FIFO_STATS_EN
    logic [31:0] xfer_cnt;
    logic        stall_seen;
`endif

    int          n_checks;
    int          n_pass;
    logic [31:0] exp_q[$];

    hs_slave_fifo_if #(.DATA_W(32)) bus ();

    hs_slave_fifo dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .count     (count),
        .afull     (afull)
`ifdef HS_FIFO_STATS_EN
        ,
        .xfer_cnt  (xfer_cnt),
        .stall_seen(stall_seen)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Scoreboard: inputs only change just after posedge, so the negedge view
    // predicts exactly which handshakes the next rising edge will perform.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("sb_underflow", 32'd0, 32'd1);
                end else begin
                    check_eq("sb_data", bus.data_out, exp_q.pop_front());
                end
            end
            if (bus.valid && bus.ready) begin
                exp_q.push_back(bus.data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bus.valid     = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 100 && (exp_q.size() != 0 || bus.out_valid); i++) begin
            step();
        end
        bus.out_ready = 1'b0;
        check_eq("drain_sb_empty", 32'(exp_q.size()), 32'd0);
        check_eq("drain_count", 32'(count), 32'd0);
        check_eq("drain_out_valid", 32'(bus.out_valid), 32'd0);
    endtask

    // Fill to DEPTH, hold a fifth beat while full, release one slot, accept it.
    task automatic fill_and_stall(input logic [31:0] base);
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            bus.valid = 1'b1;
            bus.data  = base + 32'(i);
            step();
            check_eq("fill_count", 32'(count), 32'(i));
            check_eq("fill_afull", 32'(afull), (i >= 3) ? 32'd1 : 32'd0);
        end
        check_eq("full_ready", 32'(bus.ready), 32'd0);
        bus.data = base + 32'd5;
        step();
        step();
        check_eq("full_hold_count", 32'(count), 32'd4);
        check_eq("full_hold_ready", 32'(bus.ready), 32'd0);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check_eq("after_pop_count", 32'(count), 32'd3);
        check_eq("after_pop_ready", 32'(bus.ready), 32'd1);
        step();
        bus.valid = 1'b0;
        check_eq("fifth_accepted_count", 32'(count), 32'd4);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit acc;
        int idx;
        n_checks      = 0;
        n_pass        = 0;
        rst_n         = 1'b0;
        bus.valid     = 1'b0;
        bus.data      = 32'd0;
        bus.out_ready = 1'b0;

        // Reset values
        #12;
        check_eq("rst_ready", 32'(bus.ready), 32'd0);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_afull", 32'(afull), 32'd0);
        check_eq("rst_data_out", bus.data_out, 32'd0);
        rst_n = 1'b1;
        step();
        check_eq("ready_after_release", 32'(bus.ready), 32'd1);

        // Single beat, one-cycle latency
        bus.valid = 1'b1;
        bus.data  = 32'hDEADBEEF;
        step();
        bus.valid = 1'b0;
        check_eq("single_out_valid", 32'(bus.out_valid), 32'd1);
        check_eq("single_data_out", bus.data_out, 32'hDEADBEEF);
        check_eq("single_count", 32'(count), 32'd1);
        drain();

        // Full / backpressure, expected order 1..5 checked by the scoreboard
        fill_and_stall(32'd0);

        // Simultaneous push and pop at count 2
        bus.valid = 1'b1;
        bus.data  = 32'h10;
        step();
        bus.data  = 32'h11;
        step();
        check_eq("sim_pre_count", 32'(count), 32'd2);
        bus.data      = 32'hA5;
        bus.out_ready = 1'b1;
        step();
        bus.valid     = 1'b0;
        bus.out_ready = 1'b0;
        check_eq("sim_count", 32'(count), 32'd2);
        check_eq("sim_head", bus.data_out, 32'h11);
        drain();

        // Wrap-around stream with toggling out_ready
        idx = 0;
        for (int cyc = 0; cyc < 200 && idx < 12; cyc++) begin
            bus.valid     = 1'b1;
            bus.data      = 32'(idx);
            bus.out_ready = (cyc % 2 == 0);
            acc           = bus.ready;
            step();
            if (acc) idx++;
        end
        check_eq("wrap_all_sent", 32'(idx), 32'd12);
        drain();

        // Mid-operation reset
        for (int i = 0; i < 3; i++) begin
            bus.valid = 1'b1;
            bus.data  = 32'h30 + 32'(i);
            step();
        end
        bus.valid = 1'b0;
        check_eq("pre_reset_count", 32'(count), 32'd3);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_count", 32'(count), 32'd0);
        check_eq("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("midrst_ready", 32'(bus.ready), 32'd0);
        check_eq("midrst_data_out", bus.data_out, 32'd0);
        exp_q.delete();
        #1;
        rst_n = 1'b1;
        step();
        check_eq("midrst_ready_back", 32'(bus.ready), 32'd1);
        bus.valid = 1'b1;
        bus.data  = 32'h77;
        step();
        bus.valid = 1'b0;
        check_eq("post_rst_head", bus.data_out, 32'h77);
        check_eq("post_rst_count", 32'(count), 32'd1);
`ifdef HS_FIFO_STATS_EN
        check_eq("stats_stall_clear", 32'(stall_seen), 32'd0);
`endif
        drain();

        // Second fill pass; with stats this is 5 more accepted beats plus stalls
        fill_and_stall(32'h100);
`ifdef HS_FIFO_STATS_EN
        check_eq("stats_xfer_cnt", xfer_cnt, 32'd6);
        check_eq("stats_stall_seen", 32'(stall_seen), 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hs_slave_fifo.md
Name: hs_slave_fifo

Overview:
- Parametrised successor to the single-register valid/ready slave.
- Accepts beats on a valid/ready input channel and buffers them in a DEPTH-entry FIFO.
- Presents the buffered beats on a valid/ready output channel in first-word fall-through form.
- Sits between a master and downstream logic and decouples their backpressure without dropping or duplicating beats.

Parameters:
- DATA_W, 32, width of the data path in bits.
- DEPTH, 4, FIFO entries; must be a power of 2 and at least 2.
- AFULL_TH, 3, count at or above which afull asserts; range 1..DEPTH.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- data  in  DATA_W  input beat.
- valid  in  1  input beat valid.
- ready  out  1  slave can accept a beat.
- data_out  out  DATA_W  head-of-FIFO beat.
- out_valid  out  1  data_out holds a valid beat.
- out_ready  in  1  downstream accepts data_out.
- count  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH.
- afull  out  1  count >= AFULL_TH.

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- While rst_n=0:
  - write and read pointers = 0, count = 0.
  - ready = 0, out_valid = 0, afull = 0.
  - data_out = 0. Memory contents are not reset.
- ready is a register. It rises on the first clk edge after rst_n deasserts, then each cycle equals !(next count == DEPTH).
- Push: valid && ready at a rising edge. Writes data into mem[wr_ptr]; wr_ptr increments modulo DEPTH (natural wrap).
- Pop: out_valid && out_ready at a rising edge. rd_ptr increments modulo DEPTH.
- out_valid = (count != 0). data_out = mem[rd_ptr], combinational read; 0 when count = 0.
- Latency: a beat pushed at edge N appears on data_out with out_valid=1 after edge N (one cycle), when the FIFO was empty.
- Simultaneous push and pop: both happen and count is unchanged.
  - At count=0 a pop cannot occur (out_valid=0), so only the push takes effect.
- Full: count = DEPTH gives ready=0. No push occurs even if out_ready=1 in the same cycle, so ready never depends combinationally on out_ready.
  - ready returns to 1 the cycle after a pop.
- Empty: out_valid=0; out_ready is ignored.
- Count update: count <= count + push - pop; never exceeds DEPTH and never underflows.
- afull is registered from the next count value.
- Protocol rules:
  - The master must hold data stable while valid && !ready. The block does not check this.
  - The block never deasserts out_valid without a pop.
  - The block never changes data_out while out_valid && !out_ready.
- Reset mid-operation: all buffered beats are discarded immediately. Outputs take their reset values asynchronously. A beat presented in the reset cycle is not accepted.
- Ordering: beats leave in exact acceptance order; no loss, no duplication.

Optional Feature:
- Macro: HS_FIFO_STATS_EN.
- Defined:
  - adds output port xfer_cnt [31:0], counting accepted input beats. Resets to 0, increments by 1 per push, wraps from 0xFFFFFFFF to 0.
  - adds sticky output stall_seen, set when valid=1 && ready=0 at a rising edge; cleared only by reset.
- Not defined: neither port exists and there is no associated logic. All other behaviour is identical.

Test Plan:
- Reset then single beat: release rst_n; ready=1 after first edge. Push 0xDEADBEEF with out_ready=0 -> next cycle out_valid=1, data_out=0xDEADBEEF, count=1.
- Fill to full, DEPTH=4: push 0x1,0x2,0x3,0x4 with out_ready=0 -> count=4, ready=0, afull=1 from count 3. A fifth beat 0x5 held valid is not accepted until one pop, then is accepted; the output sequence is 1,2,3,4,5.
- Simultaneous push/pop at count=2: valid=1, data=0xA5, out_ready=1 -> count stays 2, head advances, 0xA5 emitted after the older beats.
- Wrap-around: stream 12 beats 0..11 with out_ready toggling 1,0,1,0 -> all 12 emitted in order with pointers wrapping three times; count ends at 0 and out_valid=0.
- Mid-operation reset: with count=3, pulse rst_n low between edges -> count=0, out_valid=0, ready=0 immediately. After release, the first pushed beat 0x77 is the first output.
- HS_FIFO_STATS_EN: push 5 beats with one stalled cycle while full -> xfer_cnt=5, stall_seen=1. Preload xfer_cnt 0xFFFFFFFF and push once -> xfer_cnt=0.
